// File: rtl/fft_pkg.sv
// Purpose: shared FSM state type and parameter defaults for the FFT address sequencer.
// Latency: none; this file holds only types, constants and a constant helper.
// Backpressure: not applicable.
package fft_pkg;

  localparam int LOG2N_DEF  = 9;
  localparam int BF_LAT_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fft_state_e;

  // Bank written by the final level: levels alternate banks starting with a read of RAM0.
  function automatic logic result_bank_of(input int log2n);
    return ((log2n - 1) % 2) == 0;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Purpose: fixed-depth shift register carrying write-side control and addresses.
// Latency: DEPTH enabled cycles from d to q.
// Backpressure: en low freezes every stage; synchronous active-low clear.
module fft_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Advance all stages together on enabled cycles; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (en) begin
      stage_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/fft_addr_seq.sv
// Purpose: in-place radix-2 FFT address/bank sequencer with ping-pong RAMs.
// Latency: done 1 + LOG2N*(N/2+BF_LAT) cycles after start; writes trail reads by BF_LAT.
// Backpressure: stall freezes issue, drain counting and the write delay line.
module fft_addr_seq
  import fft_pkg::*;
#(
  parameter int LOG2N  = LOG2N_DEF,
  parameter int BF_LAT = BF_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             inv,
  input  logic             stall,
  output logic [LOG2N-1:0] rd_add_a,
  output logic [LOG2N-1:0] rd_add_b,
  output logic             rd_valid,
  output logic [LOG2N-2:0] add_tw,
  output logic             tw_conj,
  output logic             rd_bank,
  output logic [LOG2N-1:0] wr_add_a,
  output logic [LOG2N-1:0] wr_add_b,
  output logic             we0,
  output logic             we1,
  output logic             busy,
  output logic             done,
  output logic             result_bank
);

  localparam int JW  = LOG2N - 1;
  localparam int LW  = $clog2(LOG2N);
  localparam int DW  = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam int DLW = 2 + 2 * LOG2N;

  localparam logic [JW-1:0] J_LAST = '1;
  localparam logic [LW-1:0] L_LAST = LW'(LOG2N - 1);
  localparam logic [DW-1:0] D_LAST = DW'(BF_LAT - 1);

  fft_state_e    state_q, state_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [JW-1:0] j_q, j_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          inv_q, inv_d;
  logic          resb_q, resb_d;

  logic [LOG2N-1:0] a_hold_q, b_hold_q;
  logic [JW-1:0]    tw_hold_q;

  logic [2*LOG2N-1:0] rot_a, rot_b;
  logic [LOG2N-1:0]   a_now, b_now;
  logic [JW-1:0]      tw_mask, tw_now;
  logic               in_run, issue;

  logic [DLW-1:0] dl_d, dl_q;
  logic           dl_vld, dl_bank;

  assign in_run = (state_q == ST_RUN);
  assign issue  = in_run && !stall;

  // Butterfly operand addresses are 2j and 2j+1 rotated left by the level; the
  // twiddle index keeps only the top L bits of j.
  always_comb begin
    rot_a   = {2{{j_q, 1'b0}}} << lvl_q;
    rot_b   = {2{{j_q, 1'b1}}} << lvl_q;
    a_now   = rot_a[2*LOG2N-1:LOG2N];
    b_now   = rot_b[2*LOG2N-1:LOG2N];
    tw_mask = {JW{1'b1}} << (JW - int'(lvl_q));
    tw_now  = j_q & tw_mask;
  end

  // Level/butterfly sequencing; DRAIN waits for the last write of a level to land
  // before the next level may read it back.
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    j_d     = j_q;
    dcnt_d  = dcnt_q;
    inv_d   = inv_q;
    resb_d  = resb_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          lvl_d   = '0;
          j_d     = '0;
          inv_d   = inv;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          j_d = j_q + 1'b1;
          if (j_q == J_LAST) begin
            state_d = ST_DRAIN;
            dcnt_d  = '0;
            j_d     = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (!stall) begin
          if (dcnt_q == D_LAST) begin
            if (lvl_q == L_LAST) begin
              state_d = ST_DONE;
              lvl_d   = '0;
              resb_d  = result_bank_of(LOG2N);
            end else begin
              state_d = ST_RUN;
              lvl_d   = lvl_q + 1'b1;
            end
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      lvl_q   <= '0;
      j_q     <= '0;
      dcnt_q  <= '0;
      inv_q   <= 1'b0;
      resb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      j_q     <= j_d;
      dcnt_q  <= dcnt_d;
      inv_q   <= inv_d;
      resb_q  <= resb_d;
    end
  end

  // Remember the last issued addresses so they stay on the bus outside RUN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_hold_q  <= '0;
      b_hold_q  <= '0;
      tw_hold_q <= '0;
    end else if (issue) begin
      a_hold_q  <= a_now;
      b_hold_q  <= b_now;
      tw_hold_q <= tw_now;
    end
  end

  assign dl_d = {issue, lvl_q[0], a_now, b_now};

  fft_delay_line #(
    .WIDTH (DLW),
    .DEPTH (BF_LAT)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .en    (!stall),
    .d     (dl_d),
    .q     (dl_q)
  );

  assign {dl_vld, dl_bank, wr_add_a, wr_add_b} = dl_q;

  assign rd_valid    = issue;
  assign rd_add_a    = in_run ? a_now  : a_hold_q;
  assign rd_add_b    = in_run ? b_now  : b_hold_q;
  assign add_tw      = in_run ? tw_now : tw_hold_q;
  assign rd_bank     = lvl_q[0];
  assign tw_conj     = inv_q;
  assign we1         = dl_vld && !dl_bank && !stall;
  assign we0         = dl_vld &&  dl_bank && !stall;
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign result_bank = resb_q;

endmodule

// File: doc/fft_addr_seq.md
FFT_ADDR_SEQ -- requirements
Module: fft_addr_seq

Interface
REQ-001 Parameter LOG2N, default 9, log2 of FFT points N; legal range 3..12.
REQ-002 Parameter BF_LAT, default 3, butterfly datapath latency in cycles from read-address issue to write; legal range 1..8.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a transform; sampled only in IDLE.
REQ-006 inv  input  1  inverse-transform mode; sampled with start.
REQ-007 stall  input  1  freezes issue counters, drain counter and write delay line while high.
REQ-008 rd_add_a, rd_add_b  output  LOG2N each  read addresses of the butterfly A and B operands.
REQ-009 rd_valid  output  1  read addresses valid this cycle.
REQ-010 add_tw  output  LOG2N-1  twiddle ROM address.
REQ-011 tw_conj  output  1  conjugate the twiddle; equals latched inv.
REQ-012 rd_bank  output  1  bank being read: 0 = RAM0, 1 = RAM1.
REQ-013 wr_add_a, wr_add_b  output  LOG2N each  write addresses, equal to the read addresses delayed by BF_LAT unstalled cycles.
REQ-014 we0, we1  output  1 each  write enables for RAM0 and RAM1.
REQ-015 busy  output  1  high in RUN and DRAIN.
REQ-016 done  output  1  one-cycle pulse when the last write of the transform has completed.
REQ-017 result_bank  output  1  bank holding the final result, valid from done until the next start.

Function
REQ-018 FSM states: IDLE, RUN, DRAIN, DONE; IDLE plus start -> RUN; RUN, last butterfly of the level issued -> DRAIN; DRAIN, BF_LAT cycles elapsed -> RUN at the next level, or DONE after the last level; DONE -> IDLE after 1 cycle.
REQ-019 Counters: level L in 0..LOG2N-1 and butterfly j in 0..N/2-1; in RUN with stall low, issue one butterfly per cycle and increment j, wrapping to 0 at N/2-1.
REQ-020 Read addresses: rd_add_a = rotl_LOG2N(2j, L); rd_add_b = rotl_LOG2N(2j+1, L); rotation is a LOG2N-bit circular left rotate.
REQ-021 Twiddle address: add_tw = j with its low (LOG2N-1-L) bits cleared; at L = 0, add_tw = 0.
REQ-022 Banks: rd_bank = L[0]; writes go to the opposite bank of the issuing level; we1 = delayed valid AND NOT delayed bank; we0 = delayed valid AND delayed bank.
REQ-023 Write delay line: a BF_LAT-deep shift register carries the valid bit, both addresses and the bank bit; it does not advance while stall is high.
REQ-024 The DRAIN state guarantees that the first read of level L+1 occurs no earlier than the cycle after the last write of level L.
REQ-025 With stall held low, done asserts exactly 1 + LOG2N*(N/2+BF_LAT) cycles after the cycle in which start was sampled.
REQ-026 result_bank = (LOG2N-1)[0] XOR 1, the bank written by the last level.
REQ-027 start while busy or in DONE is ignored; inv is latched only on an accepted start.
REQ-028 stall does not affect the FSM state; rd_valid, we0 and we1 are forced low while stall is high.
REQ-029 Outside RUN, rd_valid is 0 and the address outputs hold their last values.

Reset
REQ-030 While reset is low at a clock edge: state IDLE; L, j and the drain counter 0; delay line cleared; all outputs 0. This applies mid-transform and no pending write completes.

Structure
REQ-031 A shared package fft_pkg holds the FSM state enum and the LOG2N and BF_LAT defaults.
REQ-032 The delay line is the single sub-module fft_delay_line, parameterised by width and depth.

Verification (LOG2N=3, BF_LAT=2 unless noted)
REQ-033 Start pulse at t0, no stall -> done at t0+19 and only then; busy high t0+1..t0+18; result_bank = 1.
REQ-034 Level 1, j=1 -> rd_add_a = 4, rd_add_b = 6, add_tw = 0; level 2, j=1 -> rd_add_a = 1, rd_add_b = 5, add_tw = 1; j=3 at level 1 -> add_tw = 2.
REQ-035 Level 0 issues -> we1 pulses exactly 2 cycles after each rd_valid with matching wr addresses; we0 stays 0.
REQ-036 stall high for 5 cycles mid-level-1 -> no issue or write in those cycles; done delayed by exactly 5 cycles; address sequence unchanged.
REQ-037 reset low during level 2 -> next cycle all outputs 0, state IDLE; a following start runs the full 19-cycle sequence.
REQ-038 inv = 1 with start, then start re-pulsed while busy -> tw_conj = 1 throughout and no restart; default LOG2N=9, BF_LAT=3 -> done at t0+1+9*259.
